// File: rtl/keypad_code_entry.sv
// 4x4 keypad scanner, frame debouncer and 4-digit code accumulator.
// Optional KEYPAD_HEX_FILTER_EN: only 0-9 enter the code, key C clears.
module keypad_code_entry #(
    parameter int clk_freq     = 125_000_000,
    parameter int scan_hz      = 1000,
    parameter int stable_scans = 4,
    parameter int code_len     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        is_a_key_pressed,
    output logic [15:0] password,
    output logic [2:0]  digits,
    output logic        code_ready
);

    localparam int DIV = (clk_freq / scan_hz < 1) ? 1 : clk_freq / scan_hz;
    localparam int TW = $clog2(DIV + 1);
    localparam int CW = $clog2(stable_scans + 1);
    localparam logic [TW-1:0] TLAST = TW'(DIV - 1);
    localparam logic [CW-1:0] CLAST = CW'(stable_scans - 1);
    localparam logic [2:0] DLAST = 3'(code_len - 1);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

    state_t state_q, state_d;
    logic [TW-1:0] tick_q;
    logic [1:0] row_idx_q;
    logic [1:0] lows_q;
    logic [3:0] fkey_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic pressed_q, pressed_d;
    logic [3:0] key_code_q;
    logic key_valid_q;
    logic [15:0] pw_q;
    logic [2:0] dig_q;

    logic tick, frame_done, hit, accept;
    logic [2:0] low_n, sum;
    logic [1:0] low_c, sum_sat;
    logic [3:0] fkey, row_key;
    logic is_digit, clr, store;

    function automatic logic [3:0] keymap(input logic [1:0] r,
                                          input logic [1:0] c);
        logic [3:0] k;
        unique case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign tick = (tick_q == TLAST);
    assign frame_done = tick && (row_idx_q == 2'd3);
    assign row = ~(4'b0001 << row_idx_q);

    always_comb begin
        low_n = '0;
        low_c = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) begin
                low_n = low_n + 3'd1;
                low_c = 2'(i);
            end
        end
    end

    // lows_q saturates at 2: any ghost in the frame poisons it
    assign sum = {1'b0, lows_q} + low_n;
    assign sum_sat = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    assign row_key = keymap(row_idx_q, low_c);
    assign fkey = (lows_q == 2'd1) ? fkey_q : row_key;
    assign hit = (sum_sat == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            row_idx_q <= '0;
            lows_q <= '0;
            fkey_q <= '0;
        end else begin
            tick_q <= tick ? '0 : tick_q + 1'b1;
            if (tick) begin
                row_idx_q <= row_idx_q + 2'd1;
                if (frame_done) begin
                    lows_q <= '0;
                end else begin
                    lows_q <= sum_sat;
                    if (low_n == 3'd1) fkey_q <= row_key;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        cand_d = cand_q;
        pressed_d = pressed_q;
        accept = 1'b0;
        if (frame_done) begin
            unique case (state_q)
                IDLE: if (hit) begin
                    cand_d = fkey;
                    if (stable_scans <= 1) begin
                        state_d = HELD;
                        accept = 1'b1;
                        pressed_d = 1'b1;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d = CW'(1);
                    end
                end
                CONFIRM: if (hit && fkey == cand_q) begin
                    if (cnt_q >= CLAST) begin
                        state_d = HELD;
                        accept = 1'b1;
                        pressed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
                HELD: if (!hit) begin
                    if (stable_scans <= 1) begin
                        state_d = IDLE;
                        pressed_d = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        cnt_d = CW'(1);
                    end
                end
                default: if (hit) begin
                    state_d = HELD;
                end else if (cnt_q >= CLAST) begin
                    state_d = IDLE;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            cand_q <= '0;
            pressed_q <= 1'b0;
            key_code_q <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            cand_q <= cand_d;
            pressed_q <= pressed_d;
            key_valid_q <= accept;
            if (accept) key_code_q <= fkey;
        end
    end

`ifdef KEYPAD_HEX_FILTER_EN
    assign is_digit = (key_code_q <= 4'd9);
    assign clr = clear || (key_valid_q && key_code_q == 4'hC);
`else
    assign is_digit = 1'b1;
    assign clr = clear;
`endif

    assign store = key_valid_q && is_digit && !clr;
    assign code_ready = store && (dig_q == DLAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pw_q <= '0;
            dig_q <= '0;
        end else if (store) begin
            pw_q <= {pw_q[11:0], key_code_q};
            dig_q <= code_ready ? 3'd0 : dig_q + 3'd1;
        end
    end

    assign key_code = key_code_q;
    assign key_valid = key_valid_q;
    assign is_a_key_pressed = pressed_q;
    assign password = pw_q;
    assign digits = dig_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry with a behavioural 4x4 keypad.
// Stimulus changes only on frame boundaries (16 cycles after reset).
module tb_keypad_code_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        is_a_key_pressed;
    logic [15:0] password;
    logic [2:0]  digits;
    logic        code_ready;

    logic [15:0] mask;
    int errors = 0;
    int checks = 0;
    int kv_cnt = 0;
    int kv0;

    typedef struct {
        int r;
        int c;
        bit clr;
        logic [3:0] code;
        bit cr;
        logic [15:0] pw;
        logic [2:0] dg;
    } vec_t;

    vec_t tbl[7];

    keypad_code_entry #(
        .clk_freq(16),
        .scan_hz(4),
        .stable_scans(2),
        .code_len(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .col(col),
        .row(row),
        .clear(clear),
        .key_code(key_code),
        .key_valid(key_valid),
        .is_a_key_pressed(is_a_key_pressed),
        .password(password),
        .digits(digits),
        .code_ready(code_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pressed switch at (r,c) pulls col c low while row r is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r]) col = col & ~mask[r*4 +: 4];
    end

    always @(negedge clk)
        if (key_valid) kv_cnt = kv_cnt + 1;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (16 * n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] key_at(input int r, input int c);
        logic [15:0] one;
        one = 16'd1;
        return one << (r * 4 + c);
    endfunction

    initial begin
        tbl[0] = '{0, 0, 1'b0, 4'h1, 1'b0, 16'h0001, 3'd1};
        tbl[1] = '{2, 2, 1'b0, 4'h9, 1'b0, 16'h0019, 3'd2};
        tbl[2] = '{0, 3, 1'b0, 4'hA, 1'b0, 16'h019A, 3'd3};
        tbl[3] = '{3, 0, 1'b0, 4'h0, 1'b1, 16'h19A0, 3'd0};
        tbl[4] = '{0, 2, 1'b0, 4'h3, 1'b0, 16'h9A03, 3'd1};
        tbl[5] = '{2, 0, 1'b0, 4'h7, 1'b0, 16'hA037, 3'd2};
        tbl[6] = '{0, 1, 1'b1, 4'h2, 1'b0, 16'h0002, 3'd1};

        rst = 1'b1;
        clear = 1'b0;
        mask = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;

        chk("rst_key_code", 16'(key_code), 16'h0);
        chk("rst_key_valid", 16'(key_valid), 16'h0);
        chk("rst_pressed", 16'(is_a_key_pressed), 16'h0);
        chk("rst_password", password, 16'h0);
        chk("rst_digits", 16'(digits), 16'h0);
        chk("rst_code_ready", 16'(code_ready), 16'h0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] er;
            er = ~(4'b0001 << i);
            chk("row_seq", 16'(row), 16'(er));
            repeat (4) @(negedge clk);
            #1;
        end

        kv0 = kv_cnt;
        mask = key_at(1, 2);
        frames(1);
        chk("k6_confirm_kv", 16'(key_valid), 16'h0);
        chk("k6_confirm_pr", 16'(is_a_key_pressed), 16'h0);
        frames(1);
        chk("k6_kv", 16'(key_valid), 16'h1);
        chk("k6_code", 16'(key_code), 16'h6);
        chk("k6_pressed", 16'(is_a_key_pressed), 16'h1);
        frames(3);
        chk("k6_one_pulse", 16'(kv_cnt - kv0), 16'd1);
        chk("k6_still_held", 16'(is_a_key_pressed), 16'h1);
        mask = '0;
        frames(1);
        chk("k6_rel1", 16'(is_a_key_pressed), 16'h1);
        frames(1);
        chk("k6_rel2", 16'(is_a_key_pressed), 16'h0);
        chk("k6_password", password, 16'h0006);

        kv0 = kv_cnt;
        for (int i = 0; i < 6; i++) begin
            mask = (i % 2 == 0) ? key_at(1, 1) : 16'h0;
            frames(1);
        end
        mask = '0;
        frames(1);
        chk("bounce_no_kv", 16'(kv_cnt - kv0), 16'd0);
        mask = key_at(0, 0) | key_at(2, 1);
        frames(4);
        chk("ghost_pressed", 16'(is_a_key_pressed), 16'h0);
        mask = '0;
        frames(2);
        chk("ghost_no_kv", 16'(kv_cnt - kv0), 16'd0);

        do_reset();
        #1;
        chk("rst_clears_pw", password, 16'h0);
        for (int i = 0; i < 7; i++) begin
            mask = key_at(tbl[i].r, tbl[i].c);
            clear = tbl[i].clr;
            @(negedge clk);
            clear = 1'b0;
            repeat (31) @(negedge clk);
            #1;
            chk("tbl_kv", 16'(key_valid), 16'h1);
            chk("tbl_code", 16'(key_code), 16'(tbl[i].code));
            chk("tbl_code_ready", 16'(code_ready), 16'(tbl[i].cr));
            mask = '0;
            frames(2);
            chk("tbl_password", password, tbl[i].pw);
            chk("tbl_digits", 16'(digits), 16'(tbl[i].dg));
        end

        mask = key_at(1, 1);
        frames(2);
        clear = 1'b1;
        #1;
        chk("clr_kv_pulse", 16'(key_valid), 16'h1);
        chk("clr_no_ready", 16'(code_ready), 16'h0);
        @(negedge clk);
        clear = 1'b0;
        mask = '0;
        repeat (31) @(negedge clk);
        #1;
        chk("clr_wins_pw", password, 16'h0);
        chk("clr_wins_dg", 16'(digits), 16'h0);

        do_reset();
        kv0 = kv_cnt;
        mask = key_at(2, 1);
        frames(2);
        chk("k8_kv", 16'(key_valid), 16'h1);
        chk("k8_code", 16'(key_code), 16'h8);
        mask = key_at(2, 2);
        frames(3);
        chk("slide_one_pulse", 16'(kv_cnt - kv0), 16'd1);
        chk("slide_code", 16'(key_code), 16'h8);
        chk("slide_pressed", 16'(is_a_key_pressed), 16'h1);
        do_reset();
        #1;
        chk("midrst_pressed", 16'(is_a_key_pressed), 16'h0);
        chk("midrst_code", 16'(key_code), 16'h0);
        frames(1);
        chk("k9_confirm", 16'(key_valid), 16'h0);
        frames(1);
        chk("k9_kv", 16'(key_valid), 16'h1);
        chk("k9_code", 16'(key_code), 16'h9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
